alu_sequencer: RTL and testbench

//  Multi-cycle control unit for the CPU-Core 8-bit ALU datapath. Fetches 16-bit instructions over a
//  req/ack port, decodes them, and drives ALU select/rotate/operands from a 4x8 register file.

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/cpu_regfile.sv | 42 ++++
 rtl/alu_sequencer.sv | 176 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants, instruction field positions and FSM state
//               encoding for the ALU sequencer and its register file.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_PC_W   = 8;
    localparam int INSTR_W    = 16;
    localparam int REG_ADDR_W = 2;

    // Instruction classes held in bits [15:14]
    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_LDI  = 2'b01;
    localparam logic [1:0] CLS_JZ   = 2'b10;
    localparam logic [1:0] CLS_HALT = 2'b11;

    // Instruction field bit positions
    localparam int F_CLS_HI = 15;
    localparam int F_CLS_LO = 14;
    localparam int F_SEL_HI = 13;
    localparam int F_SEL_LO = 10;
    localparam int F_ROT_HI = 9;
    localparam int F_ROT_LO = 8;
    localparam int F_RD_HI  = 7;
    localparam int F_RD_LO  = 6;
    localparam int F_RA_HI  = 5;
    localparam int F_RA_LO  = 4;
    localparam int F_RB_HI  = 3;
    localparam int F_RB_LO  = 2;
    localparam int F_LRD_HI = 9;   // LDI destination register
    localparam int F_LRD_LO = 8;
    localparam int F_IMM_HI = 7;   // LDI immediate / JZ target
    localparam int F_IMM_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cpu_regfile
// Description : 4-entry register file, two asynchronous read ports and one
//               synchronous write port, asynchronously cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr0,
    input  logic [REG_ADDR_W-1:0] i_raddr1,
    output logic [DATA_W-1:0]     o_rdata0,
    output logic [DATA_W-1:0]     o_rdata1
);

    logic [DATA_W-1:0] r_mem [2**REG_ADDR_W];

    // Storage: cleared on reset, one write per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**REG_ADDR_W; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Multi-cycle control unit: fetches 16-bit instructions over a
//               req/ack port, drives an external combinational ALU from a
//               4x8 register file and writes results back. Keeps PC and a
//               zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              DATA_W   = 8,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [DATA_W-1:0]  alu_in0,
    output logic [DATA_W-1:0]  alu_in1,
    output logic [3:0]         alu_select,
    output logic [1:0]         alu_rotate,
    input  logic [DATA_W-1:0]  alu_out,
    output logic               busy,
    output logic               halted,
    output logic [PC_W-1:0]    pc,
    output logic               zero_flag
);

    state_t                r_state;
    state_t                w_next_state;
    logic [INSTR_W-1:0]    r_instr;
    logic [PC_W-1:0]       r_pc;
    logic                  r_zero;
    logic [DATA_W-1:0]     r_result;

    // Fields latched in DECODE and held through WB
    logic [1:0]            r_cls;
    logic [3:0]            r_sel;
    logic [1:0]            r_rot;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [REG_ADDR_W-1:0] r_ra;
    logic [REG_ADDR_W-1:0] r_rb;
    logic [7:0]            r_imm;

    logic [1:0]            w_dec_cls;
    logic                  w_alu_drive;
    logic                  w_rf_we;
    logic [DATA_W-1:0]     w_rf_wdata;
    logic [DATA_W-1:0]     w_rd0;
    logic [DATA_W-1:0]     w_rd1;

    assign w_dec_cls = r_instr[F_CLS_HI:F_CLS_LO];

    cpu_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (reset),
        .i_we     (w_rf_we),
        .i_waddr  (r_rd),
        .i_wdata  (w_rf_wdata),
        .i_raddr0 (r_ra),
        .i_raddr1 (r_rb),
        .o_rdata0 (w_rd0),
        .o_rdata1 (w_rd1)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus fetch request, ALU drive and writeback strobes
    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        w_alu_drive  = 1'b0;
        w_rf_we      = 1'b0;
        w_rf_wdata   = r_result;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (start) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                w_next_state = (w_dec_cls == CLS_HALT) ? ST_HALTED : ST_EXEC;
            end
            ST_EXEC: begin
                w_alu_drive  = (r_cls == CLS_ALU);
                w_next_state = ST_WB;
            end
            ST_WB: begin
                w_alu_drive  = (r_cls == CLS_ALU);
                w_rf_we      = (r_cls == CLS_ALU) || (r_cls == CLS_LDI);
                w_rf_wdata   = (r_cls == CLS_LDI) ? DATA_W'(r_imm) : r_result;
                w_next_state = ST_FETCH;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: instruction capture, field latch, result, PC and zero flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr  <= '0;
            r_pc     <= START_PC;
            r_zero   <= 1'b0;
            r_result <= '0;
            r_cls    <= '0;
            r_sel    <= '0;
            r_rot    <= '0;
            r_rd     <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_imm    <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start) r_pc <= START_PC;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_data;
                        r_pc    <= r_pc + 1'b1;
                    end
                end
                ST_DECODE: begin
                    r_cls <= w_dec_cls;
                    r_sel <= r_instr[F_SEL_HI:F_SEL_LO];
                    r_rot <= r_instr[F_ROT_HI:F_ROT_LO];
                    r_rd  <= (w_dec_cls == CLS_LDI) ? r_instr[F_LRD_HI:F_LRD_LO]
                                                    : r_instr[F_RD_HI:F_RD_LO];
                    r_ra  <= r_instr[F_RA_HI:F_RA_LO];
                    r_rb  <= r_instr[F_RB_HI:F_RB_LO];
                    r_imm <= r_instr[F_IMM_HI:F_IMM_LO];
                end
                ST_EXEC: begin
                    if (r_cls == CLS_ALU) r_result <= alu_out;
                end
                ST_WB: begin
                    if (r_cls == CLS_ALU) r_zero <= (r_result == '0);
                    // A taken jump overrides the already-incremented PC
                    if ((r_cls == CLS_JZ) && r_zero) r_pc <= PC_W'(r_imm);
                end
                default: ;
            endcase
        end
    end

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign zero_flag  = r_zero;
    assign alu_in0    = w_alu_drive ? w_rd0 : '0;
    assign alu_in1    = w_alu_drive ? w_rd1 : '0;
    assign alu_select = w_alu_drive ? r_sel : '0;
    assign alu_rotate = w_alu_drive ? r_rot : '0;
    assign busy       = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                        (r_state == ST_EXEC)  || (r_state == ST_WB);
    assign halted     = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench: behavioural ALU and instruction ROM with
//               random ack delay; an instruction-level model tracks PC,
//               registers and zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam logic [7:0] START_PC = 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [7:0]  alu_in0;
    logic [7:0]  alu_in1;
    logic [3:0]  alu_select;
    logic [1:0]  alu_rotate;
    logic [7:0]  alu_out;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;
    logic        zero_flag;

    int n_vec = 0;
    int n_err = 0;
    int n_halts = 0;

    logic [15:0] rom [256];
    logic [7:0]  m_reg [4];
    logic [7:0]  m_pc;
    logic        m_zf;

    alu_sequencer #(
        .PC_W     (8),
        .DATA_W   (8),
        .START_PC (START_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .alu_in0    (alu_in0),
        .alu_in1    (alu_in1),
        .alu_select (alu_select),
        .alu_rotate (alu_rotate),
        .alu_out    (alu_out),
        .busy       (busy),
        .halted     (halted),
        .pc         (pc),
        .zero_flag  (zero_flag)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: op by select, then rotate stage
    function automatic logic [7:0] f_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] sel, input logic [1:0] rot);
        logic [7:0] r;
        case (sel)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = ~a;
            4'd6:    r = a;
            4'd7:    r = b;
            default: r = a + b + 8'd1;
        endcase
        case (rot)
            2'd1:    r = {r[6:0], r[7]};
            2'd2:    r = {r[0], r[7:1]};
            2'd3:    r = {r[3:0], r[7:4]};
            default: ;
        endcase
        return r;
    endfunction

    assign alu_out = f_alu(alu_in0, alu_in1, alu_select, alu_rotate);

    function automatic logic [15:0] enc_alu(input logic [3:0] sel, input logic [1:0] rd,
                                            input logic [1:0] ra, input logic [1:0] rb);
        return {2'b00, sel, 2'b00, rd, ra, rb, 2'b00};
    endfunction
    function automatic logic [15:0] enc_ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {2'b01, 4'h0, rd, imm};
    endfunction
    function automatic logic [15:0] enc_jz(input logic [7:0] tgt);
        return {2'b10, 6'h00, tgt};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Second directed program, loaded after the first HALT
    task automatic load_prog2();
        rom[8'h00] = enc_jz(8'h50);
        rom[8'h01] = enc_alu(4'd1, 2'd0, 2'd3, 2'd3);   // r0 = r3 - r3 -> 0
        rom[8'h02] = enc_jz(8'h20);                     // taken
        rom[8'h20] = enc_alu(4'd0, 2'd0, 2'd1, 2'd2);   // r0 = r1 + r2 (nonzero)
        rom[8'h21] = enc_jz(8'h30);                     // not taken
        rom[8'h22] = enc_alu(4'd1, 2'd0, 2'd1, 2'd1);   // zero
        rom[8'h23] = enc_jz(8'h24);                     // jump to pc+1
        rom[8'h24] = enc_jz(8'hFF);                     // to end of address space
        rom[8'hFF] = enc_ldi(2'd2, 8'h80);              // pc wraps to 00 after this
    endtask

    // One instruction: fetch handshake, decode, then EXEC/WB or HALTED
    task automatic do_instr(input int force_d);
        int          d;
        logic [15:0] iw;
        logic [1:0]  cls;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  res;
        d = (force_d >= 0) ? force_d : int'($urandom_range(0, 3));
        check("fetch_pc", pc, m_pc);
        check("fetch_zf", zero_flag, m_zf);
        for (int k = 0; k <= d; k++) begin
            check("fetch_req", imem_req, 1'b1);
            check("fetch_addr", imem_addr, m_pc);
            check("fetch_busy", busy, 1'b1);
            imem_ack  = (k == d);
            imem_data = (k == d) ? rom[m_pc] : 16'($urandom);
            @(negedge clk);
        end
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        iw   = rom[m_pc];
        m_pc = m_pc + 8'd1;
        cls  = iw[15:14];
        check("dec_req", imem_req, 1'b0);
        check("dec_pc", pc, m_pc);
        check("dec_sel", alu_select, 4'd0);
        check("dec_in0", alu_in0, 8'd0);
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        if (cls == 2'b11) begin
            check("halt_halted", halted, 1'b1);
            check("halt_busy", busy, 1'b0);
            check("halt_pc", pc, m_pc);
            @(negedge clk);
            check("halt_hold", halted, 1'b1);
            check("halt_req", imem_req, 1'b0);
            n_halts++;
            if (n_halts == 1) load_prog2();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            m_pc = START_PC;
            return;
        end
        a   = m_reg[iw[5:4]];
        b   = m_reg[iw[3:2]];
        res = f_alu(a, b, iw[13:10], iw[9:8]);
        for (int ph = 0; ph < 2; ph++) begin
            check(ph == 0 ? "exec_busy" : "wb_busy", busy, 1'b1);
            check(ph == 0 ? "exec_req" : "wb_req", imem_req, 1'b0);
            if (cls == 2'b00) begin
                check(ph == 0 ? "exec_in0" : "wb_in0", alu_in0, a);
                check(ph == 0 ? "exec_in1" : "wb_in1", alu_in1, b);
                check(ph == 0 ? "exec_sel" : "wb_sel", alu_select, iw[13:10]);
                check(ph == 0 ? "exec_rot" : "wb_rot", alu_rotate, iw[9:8]);
            end else begin
                check(ph == 0 ? "exec_in0_idle" : "wb_in0_idle", alu_in0, 8'd0);
                check(ph == 0 ? "exec_sel_idle" : "wb_sel_idle", alu_select, 4'd0);
            end
            @(negedge clk);
        end
        case (cls)
            2'b00: begin
                m_reg[iw[7:6]] = res;
                m_zf = (res == 8'd0);
            end
            2'b01:   m_reg[iw[9:8]] = iw[7:0];
            default: if (m_zf) m_pc = iw[7:0];
        endcase
    endtask

    initial begin
        int r;
        reset     = 1'b1;
        start     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;

        for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
        for (int i = 8'h50; i <= 8'hFE; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      rom[i] = 16'hC000;
            else if (r < 4)  rom[i] = enc_jz(8'($urandom_range(8'h50, 8'hFE)));
            else if (r < 8)  rom[i] = enc_ldi(2'($urandom), 8'($urandom));
            else             rom[i] = {2'b00, 14'($urandom)};
        end
        // First program: HALT at 05
        rom[8'h00] = enc_ldi(2'd1, 8'h3C);
        rom[8'h01] = enc_ldi(2'd2, 8'h05);
        rom[8'h02] = enc_alu(4'd0, 2'd3, 2'd1, 2'd2);   // r3 = 3C + 05
        rom[8'h03] = enc_alu(4'd4, 2'd0, 2'd3, 2'd1);   // reads r3 back
        rom[8'h04] = enc_jz(8'h10);                     // zero_flag=0: not taken
        rom[8'h05] = 16'hC000;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_pc", pc, 8'h00);
        check("rst_req", imem_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_zf", zero_flag, 1'b0);
        check("rst_in0", alu_in0, 8'd0);
        check("rst_in1", alu_in1, 8'd0);
        check("rst_sel", alu_select, 4'd0);
        check("rst_rot", alu_rotate, 2'd0);

        // Reset in the middle of a fetch
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_req", imem_req, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("midrst_req", imem_req, 1'b0);
        check("midrst_pc", pc, 8'h00);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        reset     = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 16'hC000;
        @(negedge clk);
        imem_ack = 1'b0;
        check("late_ack_req", imem_req, 1'b0);
        check("late_ack_busy", busy, 1'b0);
        check("late_ack_halted", halted, 1'b0);
        check("late_ack_pc", pc, 8'h00);

        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_pc = START_PC;
        m_zf = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int n = 0; n < 200; n++) begin
            do_instr((n == 0) ? 3 : -1);
        end
        check("halts_seen", 16'(n_halts >= 1), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
